// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler: RAW hazard bubbles, data-memory wait/timeout FSM, branch flush.
// Optional build macro FORWARDING_EN: only load-use hazards stall (datapath forwards EXE/MEM).
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 4,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] src1_i,
    input  logic [REG_AW-1:0] src2_i,
    input  logic              src1_vld_i,
    input  logic              src2_vld_i,
    input  logic [REG_AW-1:0] exe_dest_i,
    input  logic              exe_wb_en_i,
    input  logic              exe_mem_rd_i,
    input  logic [REG_AW-1:0] mem_dest_i,
    input  logic              mem_wb_en_i,
    input  logic              branch_tkn_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              freeze_if_o,
    output logic              freeze_id_o,
    output logic              nop_id_o,
    output logic              freeze_back_o,
    output logic              flush_o,
    output logic              mem_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use, haz, mem_stall;

    assign load_use = exe_mem_rd_i & exe_wb_en_i &
                      ((src1_vld_i & (src1_i == exe_dest_i)) |
                       (src2_vld_i & (src2_i == exe_dest_i)));

`ifdef FORWARDING_EN
    assign haz = load_use;
`else
    logic hz1, hz2;
    assign hz1 = src1_vld_i & ((exe_wb_en_i & (src1_i == exe_dest_i)) |
                               (mem_wb_en_i & (src1_i == mem_dest_i)));
    assign hz2 = src2_vld_i & ((exe_wb_en_i & (src2_i == exe_dest_i)) |
                               (mem_wb_en_i & (src2_i == mem_dest_i)));
    // load_use is a subset of hz1|hz2 here; folding it in keeps every input live.
    assign haz = hz1 | hz2 | load_use;
`endif

    assign mem_stall = ((state_q == IDLE) & mem_req_i & ~mem_ready_i) |
                       (state_q == WAIT & ~mem_ready_i) |
                       (state_q == ERR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // mem_req dropping in WAIT is deliberately ignored: only ready or timeout exits.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            IDLE: begin
                if (mem_req_i && !mem_ready_i) begin
                    state_d    = WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            WAIT: begin
                if (mem_ready_i) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_MAX) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        freeze_if_o   = 1'b0;
        freeze_id_o   = 1'b0;
        nop_id_o      = 1'b0;
        freeze_back_o = 1'b0;
        flush_o       = 1'b0;
        if (!rst_ni) begin
            freeze_if_o = 1'b0;
        end else if (mem_stall) begin
            freeze_if_o   = 1'b1;
            freeze_id_o   = 1'b1;
            freeze_back_o = 1'b1;
        end else if (branch_tkn_i) begin
            flush_o = 1'b1;
        end else if (haz) begin
            freeze_if_o = 1'b1;
            freeze_id_o = 1'b1;
            nop_id_o    = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze_if_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign mem_err_o   = mem_err_q;
    assign stall_cnt_o = stall_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazards, memory wait/timeout, branch flush, counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW       = 4;
    localparam int MEM_WAIT_MAX = 15;
    localparam int CNT_W        = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] src1, src2, exe_dest, mem_dest;
    logic              src1_vld, src2_vld, exe_wb_en, exe_mem_rd, mem_wb_en;
    logic              branch_tkn, mem_req, mem_ready;
    logic              freeze_if, freeze_id, nop_id, freeze_back, flush, mem_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [1:0]        state;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW(REG_AW), .MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .src1_i(src1), .src2_i(src2), .src1_vld_i(src1_vld), .src2_vld_i(src2_vld),
        .exe_dest_i(exe_dest), .exe_wb_en_i(exe_wb_en), .exe_mem_rd_i(exe_mem_rd),
        .mem_dest_i(mem_dest), .mem_wb_en_i(mem_wb_en), .branch_tkn_i(branch_tkn),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .freeze_if_o(freeze_if), .freeze_id_o(freeze_id), .nop_id_o(nop_id),
        .freeze_back_o(freeze_back), .flush_o(flush), .mem_err_o(mem_err),
        .stall_cnt_o(stall_cnt), .state_o(state)
    );

    // Outputs packed as {freeze_if, freeze_id, nop_id, freeze_back, flush}.
    function automatic logic [4:0] ctl();
        return {freeze_if, freeze_id, nop_id, freeze_back, flush};
    endfunction

    task automatic idle_inputs();
        src1 = 4'd0; src2 = 4'd0; src1_vld = 1'b0; src2_vld = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_rd = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        branch_tkn = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        src1 = 4'd3; src1_vld = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; mem_req = 1'b1;
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (ctl() !== 5'b0 || mem_err !== 1'b0 || stall_cnt !== '0 || state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset: ctl=%b err=%b cnt=%0d st=%0d, want all 0", ctl(), mem_err, stall_cnt, state);
        end
        do_reset();
    endtask

    typedef struct {
        logic [3:0] s1, s2;
        logic       v1, v2;
        logic [3:0] ed;
        logic       ewb, erd;
        logic [3:0] md;
        logic       mwb;
        logic       haz_full, haz_fwd;
    } hz_vec_t;

    task automatic test_hazard();
        hz_vec_t v[7];
        logic    eh;
        v[0] = '{4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
        v[1] = '{4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1};
        v[2] = '{4'd1, 4'd7, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0};
        v[3] = '{4'd5, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0};
        v[4] = '{4'd5, 4'd6, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0};
        v[5] = '{4'd9, 4'd4, 1'b1, 1'b1, 4'd4, 1'b1, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1};
        v[6] = '{4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            src1 = v[i].s1; src2 = v[i].s2; src1_vld = v[i].v1; src2_vld = v[i].v2;
            exe_dest = v[i].ed; exe_wb_en = v[i].ewb; exe_mem_rd = v[i].erd;
            mem_dest = v[i].md; mem_wb_en = v[i].mwb;
`ifdef FORWARDING_EN
            eh = v[i].haz_fwd;
`else
            eh = v[i].haz_full;
`endif
            @(negedge clk);
            tests_run++;
            if (ctl() !== {eh, eh, eh, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL hazard[%0d]: ctl=%b want %b", i, ctl(), {eh, eh, eh, 1'b0, 1'b0});
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        int fb = 0;
        idle_inputs();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (freeze_back) fb++;
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        if (freeze_back) fb++;
        tests_run++;
        if (fb !== 3 || ctl() !== 5'b0 || state !== S_WAIT) begin
            tests_failed++;
            $display("FAIL mem_wait: freeze_back cycles=%0d ctl=%b st=%0d, want 3 00000 %0d", fb, ctl(), state, S_WAIT);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (state !== S_IDLE || mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mem_wait_idle: st=%0d err=%b, want %0d 0", state, mem_err, S_IDLE);
        end
        tick();
    endtask

    task automatic test_branch();
        idle_inputs();
        src1 = 4'd3; src1_vld = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_rd = 1'b1;
        branch_tkn = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ctl() !== 5'b00001) begin
            tests_failed++;
            $display("FAIL branch_over_hazard: ctl=%b want 00001", ctl());
        end
        tick();
        idle_inputs();
        mem_req = 1'b1;
        branch_tkn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl() !== 5'b11010) begin
                tests_failed++;
                $display("FAIL branch_in_wait[%0d]: ctl=%b want 11010", i, ctl());
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ctl() !== 5'b00001) begin
            tests_failed++;
            $display("FAIL branch_after_wait: ctl=%b want 00001", ctl());
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int  stalls = 0;
        logic seen = 1'b0;
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_err) begin
                seen = 1'b1;
                break;
            end
            if (freeze_if) stalls++;
            tick();
        end
        tests_run++;
        if (!seen || stalls !== MEM_WAIT_MAX + 1 || state !== S_ERR) begin
            tests_failed++;
            $display("FAIL timeout: seen=%b stalls=%0d st=%0d, want 1 %0d %0d", seen, stalls, state, MEM_WAIT_MAX + 1, S_ERR);
        end
        tick();
        mem_req = 1'b0; mem_ready = 1'b1; branch_tkn = 1'b1;
        tick();
        tick();
        @(negedge clk);
        tests_run++;
        if (mem_err !== 1'b1 || ctl() !== 5'b11010 || state !== S_ERR) begin
            tests_failed++;
            $display("FAIL err_sticky: err=%b ctl=%b st=%0d, want 1 11010 %0d", mem_err, ctl(), state, S_ERR);
        end
        tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_err !== 1'b0 || ctl() !== 5'b0 || state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL err_reset: err=%b ctl=%b st=%0d, want 0 00000 0", mem_err, ctl(), state);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ctl() !== 5'b0 || mem_err !== 1'b0 || stall_cnt !== '0 || state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: ctl=%b err=%b cnt=%0d st=%0d, want all 0", ctl(), mem_err, stall_cnt, state);
        end
        do_reset();
    endtask

    task automatic test_stall_cnt();
        do_reset();
        src1 = 4'd3; src1_vld = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_rd = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        tests_run++;
        if (stall_cnt !== 8'd10) begin
            tests_failed++;
            $display("FAIL stall_cnt_10: got %0d want 10", stall_cnt);
        end
        for (int i = 10; i < (1 << CNT_W) + 5; i++) tick();
        @(negedge clk);
        tests_run++;
        if (stall_cnt !== 8'hFF) begin
            tests_failed++;
            $display("FAIL stall_cnt_sat: got %0d want 255", stall_cnt);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        test_reset();
        test_hazard();
        test_mem_wait();
        test_branch();
        test_timeout();
        test_reset_mid_wait();
        test_stall_cnt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
